// File: rtl/perceptron_trainer.sv
// perceptron_trainer: serial single-layer perceptron trainer over an 8-bit
// binary feature vector. Each accepted sample is scored by accumulating the
// selected weights one index per cycle. The sum is compared against the
// threshold. On a misclassification the selected weights are nudged by RATE
// toward the target, one index per cycle, saturating at 0 and 255.
//
// Optional feature: define BIAS_LEARN_EN to let UPDATE also move the threshold
// once per erroneous sample, on index 0. The cycle timing is the same with or
// without it.
//
// Handshake: a sample transfers on a rising edge where s_valid=1 and s_ready=1.
// s_ready is high only in IDLE while clr and rst are low. r_valid is a
// one-cycle strobe. r_pred and r_err keep their values until the next result.
module perceptron_trainer #(
  parameter logic [7:0] W_INIT      = 8'd0,
  parameter logic [7:0] THRESH_INIT = 8'd2,
  parameter logic [7:0] RATE        = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_x,
  input  logic       s_target,
  output logic       r_valid,
  output logic       r_pred,
  output logic       r_err,
  output logic [7:0] err_cnt,
  input  logic [2:0] w_sel,
  output logic [7:0] w_data,
  output logic [7:0] thr_data,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DECIDE = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  w_q [8];
  logic [7:0]  thr_q;
  logic [7:0]  cnt_q;
  logic [7:0]  x_q;
  logic        tgt_q;
  logic        pred_q;
  logic        err_q;
  logic [10:0] acc_q;
  logic [2:0]  idx_q;
  logic        r_valid_q;
  logic        r_pred_q;
  logic        r_err_q;

  logic        pred_d;
  logic        err_d;
  logic [8:0]  w_sum_d;
  logic [7:0]  w_upd_d;
`ifdef BIAS_LEARN_EN
  logic [8:0]  thr_sum_d;
  logic [7:0]  thr_upd_d;
`endif

  // Decision and saturating update values for the current weight index.
  always_comb begin
    pred_d  = (acc_q >= {3'b000, thr_q});
    err_d   = (pred_d != tgt_q);
    w_sum_d = {1'b0, w_q[idx_q]} + {1'b0, RATE};
    w_upd_d = w_q[idx_q];
    if (tgt_q) begin
      w_upd_d = w_sum_d[8] ? 8'hFF : w_sum_d[7:0];
    end else begin
      w_upd_d = (w_q[idx_q] < RATE) ? 8'h00 : (w_q[idx_q] - RATE);
    end
  end

`ifdef BIAS_LEARN_EN
  // The threshold moves against the target: down when the output should be 1.
  always_comb begin
    thr_sum_d = {1'b0, thr_q} + {1'b0, RATE};
    thr_upd_d = thr_q;
    if (tgt_q) begin
      thr_upd_d = (thr_q < RATE) ? 8'h00 : (thr_q - RATE);
    end else begin
      thr_upd_d = thr_sum_d[8] ? 8'hFF : thr_sum_d[7:0];
    end
  end
`endif

  // Training FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < 8; i++) w_q[i] <= W_INIT;
      thr_q     <= THRESH_INIT;
      cnt_q     <= 8'd0;
      x_q       <= 8'd0;
      tgt_q     <= 1'b0;
      pred_q    <= 1'b0;
      err_q     <= 1'b0;
      acc_q     <= 11'd0;
      idx_q     <= 3'd0;
      r_valid_q <= 1'b0;
      r_pred_q  <= 1'b0;
      r_err_q   <= 1'b0;
    end else if (clr) begin
      state_q   <= IDLE;
      for (int i = 0; i < 8; i++) w_q[i] <= W_INIT;
      thr_q     <= THRESH_INIT;
      cnt_q     <= 8'd0;
      acc_q     <= 11'd0;
      idx_q     <= 3'd0;
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            x_q     <= s_x;
            tgt_q   <= s_target;
            acc_q   <= 11'd0;
            idx_q   <= 3'd0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (x_q[idx_q]) acc_q <= acc_q + {3'b000, w_q[idx_q]};
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) state_q <= DECIDE;
        end
        DECIDE: begin
          pred_q <= pred_d;
          err_q  <= err_d;
          if (err_d) begin
            if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
            state_q <= UPDATE;
          end else begin
            r_valid_q <= 1'b1;
            r_pred_q  <= pred_d;
            r_err_q   <= 1'b0;
            state_q   <= DONE;
          end
        end
        UPDATE: begin
          if (x_q[idx_q]) w_q[idx_q] <= w_upd_d;
`ifdef BIAS_LEARN_EN
          if (idx_q == 3'd0) thr_q <= thr_upd_d;
`endif
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            r_valid_q <= 1'b1;
            r_pred_q  <= pred_q;
            r_err_q   <= err_q;
            state_q   <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = (state_q == IDLE) && !clr && !rst;
  assign r_valid   = r_valid_q;
  assign r_pred    = r_pred_q;
  assign r_err     = r_err_q;
  assign err_cnt   = cnt_q;
  assign w_data    = w_q[w_sel];
  assign thr_data  = thr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/perceptron_trainer.md
PERCEPTRON_TRAINER -- requirements
Module: perceptron_trainer

Interface
REQ-001 SHALL provide parameter W_INIT, default 0, meaning reset/clear value of every weight (8-bit unsigned).
REQ-002 SHALL provide parameter THRESH_INIT, default 2, meaning reset/clear value of the threshold (8-bit unsigned).
REQ-003 SHALL provide parameter RATE, default 1, meaning the learning step added to or subtracted from a weight (8-bit unsigned, 1..255).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clr  input  1  synchronous clear of weights, threshold and err_cnt.
REQ-007 s_valid  input  1  training sample offered.
REQ-008 s_ready  output  1  trainer accepts a sample this cycle.
REQ-009 s_x  input  8  binary feature vector.
REQ-010 s_target  input  1  desired classification.
REQ-011 r_valid  output  1  one-cycle result strobe.
REQ-012 r_pred  output  1  prediction made before update.
REQ-013 r_err  output  1  r_pred differed from s_target.
REQ-014 err_cnt  output  8  count of erroneous samples, saturating.
REQ-015 w_sel  input  3  weight readout index.
REQ-016 w_data  output  8  weight[w_sel], combinational readout.
REQ-017 thr_data  output  8  current threshold.

Function
REQ-018 Accept SHALL occur on a rising edge with s_valid=1 and s_ready=1; s_x and s_target SHALL be latched then.
REQ-019 s_ready SHALL be 1 only in IDLE with clr=0.
REQ-020 FSM states SHALL be IDLE, ACCUM, DECIDE, UPDATE, DONE; IDLE->ACCUM on accept.
REQ-021 ACCUM SHALL last 8 cycles, index 0..7, adding weight[i] into an 11-bit unsigned accumulator when x[i]=1; then ->DECIDE.
REQ-022 DECIDE SHALL last 1 cycle: pred = (acc >= threshold), err = (pred != target); ->UPDATE if err, else ->DONE.
REQ-023 UPDATE SHALL last 8 cycles, index 0..7; for x[i]=1, weight[i] += RATE if target=1, -= RATE if target=0; ->DONE.
REQ-024 Weight arithmetic SHALL saturate at 0 and 255; no wrap-around.
REQ-025 DONE SHALL last 1 cycle with r_valid=1, r_pred/r_err valid; ->IDLE.
REQ-026 r_valid SHALL rise 9 edges after accept edge when err=0, 17 edges when err=1.
REQ-027 r_pred and r_err SHALL hold their last values until the next DONE.
REQ-028 err_cnt SHALL increment in DECIDE when err=1, holding at 255.
REQ-029 clr SHALL, in any state, restore weights/threshold to init, zero err_cnt, abort any sample without r_valid, and enter IDLE next cycle.
REQ-030 clr coincident with s_valid SHALL drop the sample (s_ready=0).

Reset
REQ-031 rst SHALL immediately force: state IDLE, all weights W_INIT, threshold THRESH_INIT, err_cnt 0, r_valid 0, r_pred 0, r_err 0, accumulator and index 0.
REQ-032 rst asserted mid-ACCUM or mid-UPDATE SHALL discard partial updates; no r_valid for that sample.
REQ-033 s_ready SHALL be 0 while rst=1 and SHALL be 1 the first cycle after deassertion.

Configuration
REQ-034 Macro BIAS_LEARN_EN SHALL, when defined, make UPDATE also adjust the threshold once (on index 0): -= RATE if target=1, += RATE if target=0, saturating 0..255.
REQ-035 Without BIAS_LEARN_EN the threshold SHALL stay at THRESH_INIT except via rst/clr; timing identical either way.

Verification
REQ-036 Defaults, s_x=0x03, s_target=1 -> acc 0, r_pred=0, r_err=1 at edge 17; w[0]=w[1]=1, others 0; err_cnt=1; thr_data=1 with BIAS_LEARN_EN, 2 without.
REQ-037 Repeat same sample -> r_pred=1, r_err=0, r_valid at edge 9, weights unchanged, err_cnt=1.
REQ-038 W_INIT=255, s_x=0xFF, s_target=1, THRESH_INIT=2 -> r_pred=1, no update; then s_target=0 -> all weights 254; W_INIT=0, s_x=0xFF, s_target=0, THRESH_INIT=0 -> weights stay 0 (saturation).
REQ-039 rst pulse at UPDATE index 4 -> no r_valid, all weights W_INIT, s_ready=1 the cycle after release.
REQ-040 clr asserted together with s_valid in IDLE -> sample not accepted, no r_valid within 20 cycles; 300 erroneous samples -> err_cnt=255.
